io_ring_pwr_seq: RTL
====================

Name: io_ring_pwr_seq

Overview:
- Sequencer for IO-ring supply banks; sits directly upstream of the pad and rail-short cells of the EG 1.8 V IO ring.
- Power-up: enables bank supply switches one at a time and waits for each bank's power-good. Then releases pad isolation and retention in order.
- Power-down: reverses the sequence.
- Gives the core a ready/busy/fault view of the IO ring.

Parameters:
- NUM_BANKS, 4, number of independently switched IO supply banks (1..8)
- SETTLE_CYC, 16, settle wait in clk cycles after each step (>=1)
- TIMEOUT_CYC, 1024, max clk cycles to wait for a bank's power-good (only with IO_SEQ_TIMEOUT_EN)

Ports:
- clk  input  1  sequencer clock
- rst  input  1  synchronous, active-high reset
- start_i  input  1  power-up request, level-sampled
- stop_i  input  1  power-down request, level-sampled
- pgood_i  input  NUM_BANKS  per-bank power-good from analog; asynchronous, 2-flop synchronised internally
- sw_en_o  output  NUM_BANKS  per-bank supply switch enable
- iso_o  output  1  pad isolation, 1 = isolated
- ret_o  output  1  pad retention, 1 = retaining
- ready_o  output  1  ring fully powered, pads live
- busy_o  output  1  sequence in progress
- bank_idx_o  output  3  bank currently being stepped
- fault_o  output  1  sticky fault flag
- fault_code_o  output  2  00 none, 01 power-good loss, 10 power-good timeout

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - sw_en_o=0, iso_o=1, ret_o=1
  - ready_o=0, busy_o=0, bank_idx_o=0
  - fault_o=0, fault_code_o=00
  - state OFF, counters 0, synchroniser flops 0
- Reset mid-sequence:
  - Switches drop, isolation and retention assert, all in the cycle after rst is sampled.
  - No reverse ordering is applied.
- pgood_s is pgood_i after 2 flops; all decisions use pgood_s.
- FSM states: OFF, RAMP, SETTLE, REL_ISO, REL_RET, ON, DN_ISO, DN_BANK.
- OFF:
  - start_i=1 and stop_i=0 -> RAMP with k=0.
  - This transition also clears fault_o and fault_code_o.
- RAMP:
  - sw_en_o[k]=1 from the first RAMP cycle.
  - pgood_s[k]=1 -> SETTLE, counter loaded with SETTLE_CYC-1.
- SETTLE:
  - Counter decrements each cycle.
  - At 0: if k<NUM_BANKS-1, increment k and go to RAMP; else go to REL_ISO.
- REL_ISO: iso_o=0 on entry, wait SETTLE_CYC cycles -> REL_RET.
- REL_RET: ret_o=0 on entry, ready_o=1 the same cycle -> ON.
- Latency: with pgood_i held high before start, ready_o rises NUM_BANKS*(SETTLE_CYC+1)+SETTLE_CYC+1 cycles after start_i is sampled.
- ON:
  - start_i is ignored.
  - stop_i -> DN_ISO.
  - Any enabled bank with pgood_s=0 -> DN_ISO, fault_o=1, fault_code_o=01.
- DN_ISO:
  - ready_o=0, ret_o=1, iso_o=1 on entry.
  - Wait SETTLE_CYC cycles -> DN_BANK at the highest enabled bank.
- DN_BANK:
  - Clear sw_en_o[k], wait SETTLE_CYC cycles.
  - If k>0, decrement k and repeat; else go to OFF.
- stop_i during RAMP, SETTLE, REL_ISO or REL_RET -> DN_ISO. Power-down then starts from the highest enabled bank.
- Simultaneous start_i and stop_i: stop wins in every state. In OFF the request is ignored.
- busy_o=1 in every state except OFF and ON.
- bank_idx_o = k, zero-extended.
- Power-good loss on an already-settled bank during power-up is handled the same as in ON.
- fault_o and fault_code_o are sticky until the next OFF->RAMP transition or reset. The first fault code is kept.

Optional Feature:
- Macro: IO_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A timeout counter runs in RAMP and is reloaded on each RAMP entry.
  - After TIMEOUT_CYC cycles with pgood_s[k]=0: fault_o=1, fault_code_o=10, then DN_ISO.
- Without the macro:
  - RAMP waits indefinitely.
  - Code 10 is never produced and no timeout counter is synthesised.

Test Plan:
- NUM_BANKS=2, SETTLE_CYC=4, pgood_i high, start pulse -> sw_en_o 01 then 11; iso_o falls, then ret_o falls; ready_o rises exactly 15 cycles after start sampled.
- From ON, stop_i pulse -> same cycle as ready_o falls: iso_o=1, ret_o=1. sw_en_o[1] clears 4 cycles later, sw_en_o[0] 4 cycles after that, then OFF with busy_o=0.
- From ON, drop pgood_i[0] -> fault_o=1, fault_code_o=01, iso_o=1 within 3 cycles; reverse power-down completes; next start clears the fault.
- pgood_i[1] held low, start -> stuck in RAMP with bank_idx_o=1. With IO_SEQ_TIMEOUT_EN and TIMEOUT_CYC=32: fault_code_o=10 after 32 cycles, then power-down.
- start_i and stop_i high together in OFF -> nothing changes. In SETTLE of bank 0 -> DN_ISO, only bank 0 switched off.
- rst asserted while in SETTLE -> next cycle sw_en_o=0, iso_o=1, ret_o=1, all status outputs 0.

Source files
------------

// File: rtl/io_ring_pwr_seq.sv
// io_ring_pwr_seq: power sequencer for the switched supply banks of the IO ring.
// Power-up enables one bank at a time and waits for its power-good plus a
// settle time. It then releases pad isolation and then retention. Power-down
// runs the same steps in reverse.
// Optional build macro IO_SEQ_TIMEOUT_EN: bounds the wait for power-good in
// RAMP to TIMEOUT_CYC cycles and reports fault code 10 when it expires.
module io_ring_pwr_seq #(
    parameter int NUM_BANKS   = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [NUM_BANKS-1:0] pgood_i,
    output logic [NUM_BANKS-1:0] sw_en_o,
    output logic                 iso_o,
    output logic                 ret_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [2:0]           bank_idx_o,
    output logic                 fault_o,
    output logic [1:0]           fault_code_o
);

    if (NUM_BANKS < 1 || NUM_BANKS > 8) begin : g_bad_banks
        $error("io_ring_pwr_seq: NUM_BANKS must be in 1..8");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("io_ring_pwr_seq: SETTLE_CYC must be >= 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("io_ring_pwr_seq: TIMEOUT_CYC must be >= 1");
    end

    localparam int              CW        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [2:0]      LAST_BANK = 3'(NUM_BANKS - 1);

    typedef enum logic [2:0] {
        OFF, RAMP, SETTLE, REL_ISO, REL_RET, ON, DN_ISO, DN_BANK
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             k_q, k_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_BANKS-1:0]   sw_en_q, sw_en_d;
    logic                   iso_q, iso_d, ret_q, ret_d, ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic [1:0]             code_q, code_d;
    logic [NUM_BANKS-1:0]   pgood_m, pgood_s;
    logic [NUM_BANKS-1:0]   cur_bit, below, chk_mask;
    logic [2:0]             top;
    logic                   pg_cur, loss, timeout, abortable;

`ifdef IO_SEQ_TIMEOUT_EN
    localparam int            TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]            tcnt_q, tcnt_d;
`endif

    // One-hot select of a bank index; indices beyond NUM_BANKS select nothing.
    function automatic logic [NUM_BANKS-1:0] bank_bit(input logic [2:0] idx);
        logic [NUM_BANKS-1:0] b;
        b = '0;
        for (int j = 0; j < NUM_BANKS; j++) b[j] = (idx == 3'(j));
        return b;
    endfunction

    // Two-flop synchroniser for the asynchronous analog power-good inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pgood_m <= '0;
            pgood_s <= '0;
        end else begin
            pgood_m <= pgood_i;
            pgood_s <= pgood_m;
        end
    end

    // Bank bookkeeping: current bank, banks already settled, highest enabled bank,
    // and which enabled banks must currently hold power-good.
    always_comb begin
        cur_bit = bank_bit(k_q);
        below   = '0;
        top     = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            below[j] = (3'(j) < k_q);
            if (sw_en_q[j]) top = 3'(j);
        end
        pg_cur = |(pgood_s & cur_bit);
        case (state_q)
            RAMP, SETTLE:         chk_mask = below;
            REL_ISO, REL_RET, ON: chk_mask = '1;
            default:              chk_mask = '0;
        endcase
        loss      = |(sw_en_q & ~pgood_s & chk_mask);
        abortable = (state_q == RAMP) || (state_q == SETTLE) || (state_q == REL_ISO) ||
                    (state_q == REL_RET) || (state_q == ON);
    end

    // Next-state and next-output logic; an abort (stop, power-good loss, timeout)
    // overrides whatever the normal step would have done.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        sw_en_d = sw_en_q;
        iso_d   = iso_q;
        ret_d   = ret_q;
        ready_d = ready_q;
        fault_d = fault_q;
        code_d  = code_q;
        timeout = 1'b0;
`ifdef IO_SEQ_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            OFF: if (start_i && !stop_i) begin
                state_d = RAMP;
                k_d     = '0;
                sw_en_d = sw_en_q | bank_bit(3'd0);
                fault_d = 1'b0;
                code_d  = 2'b00;
`ifdef IO_SEQ_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            RAMP: begin
                if (pg_cur) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                end
`ifdef IO_SEQ_TIMEOUT_EN
                else if (tcnt_q == TIMEOUT_LD) timeout = 1'b1;
                else tcnt_d = tcnt_q + TW'(1);
`endif
            end
            SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else if (k_q == LAST_BANK) begin
                    state_d = REL_ISO;
                    iso_d   = 1'b0;
                    cnt_d   = SETTLE_LD;
                end else begin
                    state_d = RAMP;
                    k_d     = k_q + 3'd1;
                    sw_en_d = sw_en_q | bank_bit(k_q + 3'd1);
`ifdef IO_SEQ_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            REL_ISO: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else state_d = REL_RET;
            end
            REL_RET: begin
                state_d = ON;
                ret_d   = 1'b0;
                ready_d = 1'b1;
            end
            DN_ISO: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else begin
                    state_d = DN_BANK;
                    k_d     = top;
                    sw_en_d = sw_en_q & ~bank_bit(top);
                    cnt_d   = SETTLE_LD;
                end
            end
            DN_BANK: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else if (k_q != '0) begin
                    k_d     = k_q - 3'd1;
                    sw_en_d = sw_en_q & ~bank_bit(k_q - 3'd1);
                    cnt_d   = SETTLE_LD;
                end else state_d = OFF;
            end
            default: ;
        endcase
        if (abortable && (stop_i || loss || timeout)) begin
            state_d = DN_ISO;
            k_d     = k_q;
            sw_en_d = sw_en_q;
            cnt_d   = SETTLE_LD;
            iso_d   = 1'b1;
            ret_d   = 1'b1;
            ready_d = 1'b0;
            if (!fault_q && (loss || timeout)) begin
                fault_d = 1'b1;
                code_d  = loss ? 2'b01 : 2'b10;
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            k_q     <= '0;
            cnt_q   <= '0;
            sw_en_q <= '0;
            iso_q   <= 1'b1;
            ret_q   <= 1'b1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            sw_en_q <= sw_en_d;
            iso_q   <= iso_d;
            ret_q   <= ret_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

`ifdef IO_SEQ_TIMEOUT_EN
    // Power-good wait counter, restarted on every RAMP entry.
    always_ff @(posedge clk) begin
        if (rst) tcnt_q <= '0;
        else     tcnt_q <= tcnt_d;
    end
`endif

    assign sw_en_o      = sw_en_q;
    assign iso_o        = iso_q;
    assign ret_o        = ret_q;
    assign ready_o      = ready_q;
    assign busy_o       = (state_q != OFF) && (state_q != ON);
    assign bank_idx_o   = k_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;

endmodule
